alu_exec_unit: RTL and testbench

Multi-cycle integer execute unit that consumes the 5-bit ALUControl code from the ALU decoder and produces the ALU result for the RISC-V core. Sits between the decode/control path and writeback, behind a valid/ready handshake on both sides. Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, so a barrel shifter is not needed.

---
 rtl/alu_exec_unit.sv | 88 ++++++++
 tb/tb_alu_exec_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready integer execute unit with single-cycle logic/arith ops and bit-serial shifts
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_sh, alu_res;
  logic [SHW-1:0] cnt, shamt;
  logic left, arith, is_shift, bad, accept, go_shift, last;
  assign shamt = SrcB[SHW-1:0];
  assign is_shift = ALUControl == 5'd7 || ALUControl == 5'd10 || ALUControl == 5'd11;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  assign go_shift = is_shift && shamt != '0;
  assign last = cnt == SHW'(1);
  assign acc_sh = left ? {acc[WIDTH-2:0], 1'b0} : {arith & acc[WIDTH-1], acc[WIDTH-1:1]};
  always_comb begin
    alu_res = '0;
    bad = 1'b0;
    case (ALUControl)
      5'd0, 5'd8: alu_res = SrcA + SrcB;
      5'd1: alu_res = SrcA - SrcB;
      5'd2: alu_res = SrcA & SrcB;
      5'd3: alu_res = SrcA | SrcB;
      5'd4: alu_res = SrcA ^ SrcB;
      5'd5: alu_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      5'd6: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      5'd7, 5'd10, 5'd11: alu_res = SrcA;
      5'd9: alu_res = SrcB;
      default: bad = 1'b1;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = in_valid ? (go_shift ? SHIFT : DONE) : IDLE;
      SHIFT: state_n = last ? DONE : SHIFT;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      left <= 1'b0;
      arith <= 1'b0;
      ALUResult <= '0;
      Zero <= 1'b1;
      illegal <= 1'b0;
    end else if (accept) begin
      acc <= SrcA;
      cnt <= shamt;
      left <= ALUControl == 5'd7;
      arith <= ALUControl == 5'd11;
      illegal <= bad;
      if (!go_shift) begin
        ALUResult <= alu_res;
        Zero <= alu_res == '0;
      end
    end else if (state == SHIFT) begin
      acc <= acc_sh;
      cnt <= cnt - SHW'(1);
      if (last) begin
        ALUResult <= acc_sh;
        Zero <= acc_sh == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against an operator-level model
module tb_alu_exec_unit;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] ALUControl = '0;
  logic [31:0] SrcA = '0, SrcB = '0;
  logic in_ready, out_valid, Zero, illegal;
  logic [31:0] ALUResult;
  int checks = 0, failures = 0;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = $signed(a) >>> b[4:0];
    case (code)
      5'd0, 5'd8: return {1'b0, a + b};
      5'd1: return {1'b0, a - b};
      5'd2: return {1'b0, a & b};
      5'd3: return {1'b0, a | b};
      5'd4: return {1'b0, a ^ b};
      5'd5: return {1'b0, 31'b0, $signed(a) < $signed(b)};
      5'd6: return {1'b0, 31'b0, a < b};
      5'd7: return {1'b0, a << b[4:0]};
      5'd9: return {1'b0, b};
      5'd10: return {1'b0, a >> b[4:0]};
      5'd11: return {1'b0, sa};
      default: return {1'b1, 32'b0};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_result"}, ALUResult, 0);
    check({tag, "_zero"}, 32'(Zero), 1);
    check({tag, "_illegal"}, 32'(illegal), 0);
  endtask

  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input logic early);
    logic [32:0] m;
    int lat, exp_lat;
    m = model(code, a, b);
    exp_lat = ((code == 5'd7 || code == 5'd10 || code == 5'd11) && b[4:0] != 0) ? int'(b[4:0]) + 1 : 1;
    check("accept_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    ALUControl = code;
    SrcA = a;
    SrcB = b;
    tick();
    in_valid = 1'($urandom_range(0, 1));
    ALUControl = 5'($urandom);
    SrcA = $urandom;
    SrcB = $urandom;
    out_ready = early;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", 32'(in_ready), 0);
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check("latency", lat, exp_lat);
    if (!out_valid) begin
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      return;
    end
    check("result", ALUResult, m[31:0]);
    check("zero", 32'(Zero), 32'(m[31:0] == 0));
    check("illegal", 32'(illegal), 32'(m[32]));
    repeat (hold) begin
      tick();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_result", ALUResult, m[31:0]);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("post_out_valid", 32'(out_valid), 0);
    check("post_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check_reset_state("rst_held");
    reset = 1'b0;
    tick();
    check_reset_state("rst_rel");

    run_op(5'd0, 32'h5, 32'h3, 0, 1'b0);
    run_op(5'd1, 32'h1234, 32'h1234, 0, 1'b0);
    run_op(5'd5, 32'hFFFFFFFF, 32'h1, 0, 1'b0);
    run_op(5'd6, 32'hFFFFFFFF, 32'h1, 0, 1'b0);
    run_op(5'd9, 32'h0, 32'hABCDE000, 0, 1'b0);
    run_op(5'd11, 32'h80000000, 32'h1F, 0, 1'b0);
    run_op(5'd10, 32'h80000000, 32'h1F, 0, 1'b0);
    run_op(5'd7, 32'h1, 32'hFFFFFFE4, 0, 1'b1);
    run_op(5'd7, 32'hDEADBEEF, 32'h20, 0, 1'b0);
    run_op(5'd4, 32'hF0F0F0F0, 32'hFFFF0000, 10, 1'b0);
    run_op(5'h1F, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
    run_op(5'd3, 32'h0, 32'h1, 0, 1'b0);

    run_op(5'd7, 32'h1, 32'd20, 0, 1'b0);
    in_valid = 1'b1;
    ALUControl = 5'd7;
    SrcA = 32'hFFFF;
    SrcB = 32'd20;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst_shift");
    for (int i = 0; i < 25; i++) begin
      if (out_valid) check("rst_no_valid", 32'(out_valid), 0);
      tick();
    end
    check("rst_idle", 32'(in_ready), 1);
    run_op(5'd0, 32'hFFFFFFFF, 32'h1, 0, 1'b0);

    reset = 1'b1;
    in_valid = 1'b1;
    ALUControl = 5'd0;
    SrcA = 32'h7;
    SrcB = 32'h9;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check_reset_state("rst_vs_valid");
    tick();
    check("rst_vs_valid_idle", 32'(out_valid), 0);

    for (int i = 0; i < 300; i++) begin
      logic [4:0] code;
      logic [31:0] a, b;
      code = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = {a[31], 31'($urandom_range(0, 3))};
      run_op(code, a, b, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
